// File: rtl/fp_add_pkg.sv
// fp_add_pkg: fp32 field widths, packed layout and pack/unpack helpers
package fp_add_pkg;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_EXP_W = 8;
  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;
  function automatic fp32_t fp32_unpack(input logic [31:0] w);
    return fp32_t'(w);
  endfunction
  function automatic logic [31:0] fp32_pack(input fp32_t f);
    return {f.sign, f.exp, f.man};
  endfunction
endpackage

// File: rtl/fp_add_driver_if.sv
// fp_add_driver_if: operand, fp_add issue/return and result buses of fp_add_driver
interface fp_add_driver_if import fp_add_pkg::*; #(parameter int CNT_W = 3);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_a;
  logic [31:0]           in_b;
  logic                  src_valid;
  logic [FP32_MAN_W-1:0] a_man;
  logic [FP32_EXP_W-1:0] a_exp;
  logic                  a_sign;
  logic [FP32_MAN_W-1:0] b_man;
  logic [FP32_EXP_W-1:0] b_exp;
  logic                  b_sign;
  logic                  dst_valid;
  logic [FP32_MAN_W-1:0] r_man;
  logic [FP32_EXP_W-1:0] r_exp;
  logic                  r_sign;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_r;
  logic [CNT_W-1:0]      inflight;
  logic [1:0]            err;
  modport slave (
    input  in_valid, in_a, in_b, dst_valid, r_man, r_exp, r_sign, out_ready,
    output in_ready, src_valid, a_man, a_exp, a_sign, b_man, b_exp, b_sign,
           out_valid, out_r, inflight, err
  );
  modport master (
    output in_valid, in_a, in_b, dst_valid, r_man, r_exp, r_sign, out_ready,
    input  in_ready, src_valid, a_man, a_exp, a_sign, b_man, b_exp, b_sign,
           out_valid, out_r, inflight, err
  );
endinterface

// File: rtl/fp_add_res_fifo.sv
// fp_add_res_fifo: result buffer; a push into a full FIFO only lands when a pop frees the slot
module fp_add_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == CNT_W'(DEPTH);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_mem   <= '{default: '0};
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: rtl/fp_add_driver.sv
// fp_add_driver: credit-gated operand issue to fp_add and buffered, repacked result return
module fp_add_driver import fp_add_pkg::*; #(
  parameter int RES_DEPTH = 4,
  parameter int CNT_W     = $clog2(RES_DEPTH) + 1
) (
  input logic            clk,
  input logic            rst,
  fp_add_driver_if.slave bus
);
  logic [CNT_W-1:0] r_credits;
  logic [CNT_W-1:0] r_inflight;
  logic             r_src_valid;
  fp32_t            r_a;
  fp32_t            r_b;
  logic [1:0]       r_err;
  logic             w_accept;
  logic             w_pop;
  logic             w_ret;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fp32_t            w_r;
  logic [31:0]      w_head;
  assign w_r      = {bus.r_sign, bus.r_exp, bus.r_man};
  assign w_accept = bus.in_valid && r_credits != '0;
  assign w_pop    = bus.out_ready && !w_empty;
  assign w_ret    = bus.dst_valid && r_inflight != '0;
  // a pop in the same cycle frees the slot, so only an unpaired push into a full FIFO is lost
  assign w_drop   = bus.dst_valid && w_full && !w_pop;
  fp_add_res_fifo #(.DEPTH(RES_DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.dst_valid),
    .i_data  (fp32_pack(w_r)),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits   <= CNT_W'(RES_DEPTH);
      r_inflight  <= '0;
      r_src_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_err       <= '0;
    end else begin
      r_src_valid <= w_accept;
      if (w_accept) begin
        r_a <= fp32_unpack(bus.in_a);
        r_b <= fp32_unpack(bus.in_b);
      end
      r_credits  <= r_credits - CNT_W'(w_accept) + CNT_W'(w_pop);
      r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_ret);
      r_err      <= r_err | {bus.dst_valid && r_inflight == '0, w_drop};
    end
  end
  assign bus.in_ready  = r_credits != '0;
  assign bus.src_valid = r_src_valid;
  assign bus.a_sign    = r_a.sign;
  assign bus.a_exp     = r_a.exp;
  assign bus.a_man     = r_a.man;
  assign bus.b_sign    = r_b.sign;
  assign bus.b_exp     = r_b.exp;
  assign bus.b_man     = r_b.man;
  assign bus.out_valid = w_count != '0;
  assign bus.out_r     = w_head;
  assign bus.inflight  = r_inflight;
  assign bus.err       = r_err;
endmodule
